// File: rtl/mult_pkg.sv
// Shared encodings for the nibble-serial multiplier controller and its issuer.
// Used by mult_issuer and by any controller implementation on the other end.
package mult_pkg;

    localparam logic [2:0] CTL_IDLE   = 3'd0;
    localparam logic [2:0] CTL_S0     = 3'd1;
    localparam logic [2:0] CTL_S1     = 3'd2;
    localparam logic [2:0] CTL_S2     = 3'd3;
    localparam logic [2:0] CTL_S3     = 3'd4;
    localparam logic [2:0] CTL_FINISH = 3'd5;
    localparam logic [2:0] CTL_ERROR  = 3'd7;

    typedef enum logic [2:0] {
        ISS_IDLE    = 3'd0,
        ISS_ISSUE   = 3'd1,
        ISS_BUSY    = 3'd2,
        ISS_RESTART = 3'd3,
        ISS_RECOVER = 3'd4,
        ISS_RESP    = 3'd5
    } issuer_state_t;

    localparam logic [2:0] CNT_S0  = 3'd1;
    localparam logic [2:0] CNT_S1  = 3'd2;
    localparam logic [2:0] CNT_S2  = 3'd3;
    localparam logic [2:0] CNT_S3  = 3'd4;
    localparam logic [2:0] CNT_FIN = 3'd5;

    // Replacement is only safe while the controller is in S0..S2.
    function automatic logic upd_window(input logic [2:0] c);
        return (c == CNT_S0) || (c == CNT_S1) || (c == CNT_S2);
    endfunction

endpackage

// File: rtl/mult_issuer.sv
// Issuer side of the multiplier start/changed/count/done_flag protocol.
// Optional watchdog enabled by defining MULT_ISSUER_WD_EN.
module mult_issuer
    import mult_pkg::*;
#(
    parameter int OP_W   = 8,
    parameter int WD_CYC = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OP_W-1:0]     req_a,
    input  logic [OP_W-1:0]     req_b,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [OP_W-1:0]     upd_a,
    input  logic [OP_W-1:0]     upd_b,
    output logic [OP_W-1:0]     op_a,
    output logic [OP_W-1:0]     op_b,
    output logic                start,
    output logic                changed,
    output logic [2:0]          count,
    input  logic [2:0]          ctl_state,
    input  logic                done_flag,
    input  logic [2*OP_W-1:0]   product,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2*OP_W-1:0]   rsp_data,
    output logic                rsp_err
);

    issuer_state_t state;
    logic          wd_trip;

    assign req_ready = (state == ISS_IDLE);
    assign upd_ready = (state == ISS_BUSY) && upd_window(count);

`ifdef MULT_ISSUER_WD_EN
    localparam int WD_W = $clog2(WD_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    // Trips on the cycle the running count would reach the limit.
    assign wd_trip = ((state == ISS_BUSY) || (state == ISS_RECOVER)) &&
                     (wd_cnt == WD_W'(WD_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if ((state == ISS_ISSUE) || (state == ISS_RECOVER)) begin
            wd_cnt <= '0;
        end else if (state == ISS_BUSY) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    logic wd_unused;
    assign wd_unused = (WD_CYC == 0);
    assign wd_trip   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ISS_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            start     <= 1'b0;
            changed   <= 1'b0;
            count     <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            start   <= 1'b0;
            changed <= 1'b0;
            case (state)
                ISS_IDLE: begin
                    if (req_valid) begin
                        op_a  <= req_a;
                        op_b  <= req_b;
                        start <= 1'b1;
                        count <= 3'd0;
                        state <= ISS_ISSUE;
                    end
                end
                ISS_ISSUE: begin
                    count <= CNT_S0;
                    state <= ISS_BUSY;
                end
                ISS_BUSY: begin
                    if (wd_trip) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        count     <= 3'd0;
                        state     <= ISS_RESP;
                    end else if (count == CNT_FIN) begin
                        rsp_valid <= 1'b1;
                        count     <= 3'd0;
                        state     <= ISS_RESP;
                        if ((ctl_state == CTL_FINISH) && done_flag) begin
                            rsp_data <= product;
                            rsp_err  <= 1'b0;
                        end else begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end
                    end else if (upd_valid && upd_ready) begin
                        op_a    <= upd_a;
                        op_b    <= upd_b;
                        changed <= 1'b1;
                        count   <= count + 3'd1;
                        state   <= ISS_RESTART;
                    end else begin
                        count <= count + 3'd1;
                    end
                end
                ISS_RESTART: begin
                    count <= 3'd0;
                    state <= ISS_RECOVER;
                end
                ISS_RECOVER: begin
                    // The controller acknowledges changed by sitting in ERROR for one cycle.
                    if (!wd_trip && (ctl_state == CTL_ERROR) && done_flag) begin
                        count <= CNT_S0;
                        state <= ISS_BUSY;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        state     <= ISS_RESP;
                    end
                end
                ISS_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ISS_IDLE;
                    end
                end
                default: begin
                    state <= ISS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_issuer.md
# mult_issuer

Issuer for the nibble-serial multiplier control FSM: the initiating end of its start/changed/count/done_flag protocol. It accepts operand pairs over a valid/ready request port and drives `start` and the 3-bit `count` sequence in lockstep with the controller. It replaces operands mid-operation by pulsing `changed`, which forces a controlled restart, and returns the 16-bit product over a valid/ready response port.

## Interface
- `OP_W`, 8: operand width; product is 2*OP_W.
- `WD_CYC`, 8: watchdog limit in cycles (used only with `MULT_ISSUER_WD_EN`).
- `clk` in 1: clock.
- `rst` in 1: reset; one clock, asynchronous, active-low.
- `req_valid` in 1, `req_ready` out 1: operand request handshake.
- `req_a`, `req_b` in OP_W: request operands.
- `upd_valid` in 1, `upd_ready` out 1: mid-operation operand replacement.
- `upd_a`, `upd_b` in OP_W: replacement operands.
- `op_a`, `op_b` out OP_W: registered operands to datapath, stable while busy.
- `start` out 1: one-cycle start pulse to controller.
- `changed` out 1: one-cycle restart pulse to controller.
- `count` out 3: step count to controller.
- `ctl_state` in 3: controller state; encodings IDLE=0, S0=1, S1=2, S2=3, S3=4, FINISH=5, ERROR=7.
- `done_flag` in 1: controller done.
- `product` in 2*OP_W: datapath result.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_data` out 2*OP_W, `rsp_err` out 1: result and error flag.

## Operation
- Issuer states: IDLE, ISSUE, BUSY, RESTART, RECOVER, RESP.
- IDLE: `req_ready`=1. On `req_valid` latch `op_a`/`op_b` and go to ISSUE.
- ISSUE: `start`=1 and `count`=0. Next state is BUSY with `count`=1.
- BUSY: `count` increments by 1 per cycle. It tracks the controller: count 1..4 corresponds to S0..S3, count 5 to FINISH.
- At count 5:
  - If `ctl_state`==FINISH and `done_flag`=1: capture `product` into `rsp_data` with `rsp_err`=0.
  - Otherwise: `rsp_err`=1 and `rsp_data`=0.
  - In both cases go to RESP.
- `upd_ready`=1 only in BUSY with count in {1,2,3}.
  - On an update handshake at count c, load `upd_a`/`upd_b` into `op_a`/`op_b` and go to RESTART.
  - Updates at count 4 or 5 are refused, because the controller's FINISH ignores `changed`.
- RESTART: `changed`=1 for exactly one cycle; `count`=c+1 (don't-care to the controller).
- RECOVER (one cycle): `changed`=0 and `count`=0.
  - Requires `ctl_state`==ERROR with `done_flag`=1.
  - If the requirement holds, next state is BUSY with `count`=1, since the controller re-enters S0.
  - If not, go to RESP with `rsp_err`=1.
- RESP: `rsp_valid`=1, data held until `rsp_ready`, then IDLE. `req_ready`=0 throughout.
- Unlimited restarts per operation.

## Timing
- Reset values: `start`=0, `changed`=0, `count`=0, `op_a`/`op_b`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `upd_ready`=0. `req_ready`=1 from the first cycle after reset release.
- All outputs are registered except `req_ready` and `upd_ready`, which are decoded from the state register.
- Latency, no restart: request accepted at T, `start` at T+1, `count` 1..5 at T+2..T+6, `rsp_valid` at T+7.
- Each restart adds (2 + c) cycles relative to the update point.
- Reset mid-operation returns to IDLE immediately with all outputs at reset values. No response is produced.
- `req_valid` is ignored outside IDLE. `upd_valid` is ignored outside the `upd_ready` window.

## Configuration
- `MULT_ISSUER_WD_EN` defined:
  - A cycle counter runs in BUSY and RECOVER, cleared at each ISSUE and at each RECOVER exit.
  - If it reaches `WD_CYC`, go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - `start` and `changed` are forced to 0 for that cycle.
- Not defined: no watchdog. Only the count-5 and RECOVER checks raise `rsp_err`.

## Structure
- Package `mult_pkg` holds:
  - controller state encodings (IDLE..ERROR);
  - issuer state enum;
  - count constants CNT_S0=1 .. CNT_FIN=5.
- Same package is shared with the controller.
- Single module, no sub-module; counter and watchdog are inline.

## Test plan
- Clean run: req a=0x0F, b=0x11, with a model controller and datapath → `start` at T+1, `count` 1,2,3,4,5, `rsp_data`=0x00FF, `rsp_err`=0 at T+7.
- Restart: req 0x12×0x34, then update to 0x05×0x06 at count 2 → `changed` pulses one cycle, `count`=0 in the ERROR cycle then 1 on S0, `rsp_data`=0x001E.
- Update refused: `upd_valid` held at count 4 and 5 → `upd_ready`=0, `changed` stays 0, original product returned.
- Backpressure: `rsp_ready`=0 for 5 cycles → `rsp_data` stable, `req_ready`=0; a new `req_valid` is not accepted until the handshake completes.
- Protocol fault: model controller withholds FINISH at count 5 → `rsp_err`=1, `rsp_data`=0. With `MULT_ISSUER_WD_EN` and a stalled controller → `rsp_err`=1 after `WD_CYC` cycles.
- Reset at count 3 → all outputs at reset values next cycle; `req_ready`=1 after release.
